// File: rtl/axi_w_protocol_checker.sv
// axi_w_protocol_checker: passive AXI AW/W/B checker with sticky error flags, first-error capture and statistics.
// Define AXI_WCHK_STABILITY_EN to add valid/payload stability checking on err_vec[7].
module axi_w_protocol_checker #(
    parameter int AXI_MODE       = 4,
    parameter int AW_TID_WIDTH   = 1,
    parameter int LEN_WIDTH      = 8,
    parameter int AW_DEPTH       = 8,
    parameter int OUTST_WIDTH    = 4,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    check_en,
    input  logic                    aw_valid,
    input  logic                    aw_ready,
    input  logic [AW_TID_WIDTH-1:0] aw_tid,
    input  logic [LEN_WIDTH-1:0]    aw_len,
    input  logic                    w_valid,
    input  logic                    w_ready,
    input  logic                    w_last,
    input  logic [AW_TID_WIDTH-1:0] w_tid,
    input  logic                    b_valid,
    input  logic                    b_ready,
    input  logic [AW_TID_WIDTH-1:0] b_tid,
    output logic [7:0]              err_vec,
    output logic                    err_pulse,
    output logic [2:0]              first_err,
    output logic                    first_err_valid,
    output logic [CNT_WIDTH-1:0]    aw_cnt,
    output logic [CNT_WIDTH-1:0]    w_burst_cnt,
    output logic [CNT_WIDTH-1:0]    b_cnt
);
    localparam int NUM_IDS = 2 ** AW_TID_WIDTH;
    localparam int PW = $clog2(AW_DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = LEN_WIDTH + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 2);

    logic awh, wh, bh;
    assign awh = aw_valid && aw_ready;
    assign wh  = w_valid && w_ready;
    assign bh  = b_valid && b_ready;

    logic [LEN_WIDTH-1:0]    q_len_q [AW_DEPTH];
    logic [AW_TID_WIDTH-1:0] q_tid_q [AW_DEPTH];
    logic [PW-1:0]           wr_q, rd_q;
    logic [CW-1:0]           count_q, count_d;
    logic [BW-1:0]           beat_q, beat_d;
    logic                    empty, full, head_valid, pop, pop_mem, push;
    logic [LEN_WIDTH-1:0]    head_len;
    logic [AW_TID_WIDTH-1:0] head_tid;

    assign empty      = count_q == '0;
    assign full       = count_q == CW'(AW_DEPTH);
    // An AW accepted into an empty queue is already the head this cycle.
    assign head_valid = !empty || awh;
    assign head_len   = empty ? aw_len : q_len_q[rd_q];
    assign head_tid   = empty ? aw_tid : q_tid_q[rd_q];
    assign pop        = wh && w_last && head_valid;
    assign pop_mem    = pop && !empty;
    assign push       = awh && !(empty && pop) && (!full || pop);
    assign count_d    = count_q + CW'(push) - CW'(pop_mem);
    assign beat_d     = wh ? (w_last ? '0 : beat_q + BW'(1)) : beat_q;

    logic [NUM_IDS-1:0]     inc, dec;
    logic [OUTST_WIDTH-1:0] outst_q [NUM_IDS];
    logic [OUTST_WIDTH-1:0] outst_d [NUM_IDS];
    logic                   b_no_outst, outst_ovf;

    assign inc = pop ? NUM_IDS'(1) << head_tid : '0;
    assign dec = bh ? NUM_IDS'(1) << b_tid : '0;

    always_comb begin
        b_no_outst = 1'b0;
        outst_ovf  = 1'b0;
        for (int i = 0; i < NUM_IDS; i++) begin
            outst_d[i] = outst_q[i];
            if (inc[i] && !dec[i]) begin
                outst_ovf  = outst_ovf || outst_q[i] == '1;
                outst_d[i] = outst_q[i] == '1 ? outst_q[i] : outst_q[i] + OUTST_WIDTH'(1);
            end else if (dec[i] && !inc[i]) begin
                b_no_outst = b_no_outst || outst_q[i] == '0;
                outst_d[i] = outst_q[i] == '0 ? outst_q[i] : outst_q[i] - OUTST_WIDTH'(1);
            end
        end
    end

    logic [2:0]    stall;
    logic [TW-1:0] tmr_q [3];
    logic [TW-1:0] tmr_d [3];
    logic          timeout;

    assign stall = {b_valid && !b_ready, w_valid && !w_ready, aw_valid && !aw_ready};

    always_comb begin
        timeout = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tmr_d[i] = '0;
            if (stall[i] && TIMEOUT_CYCLES != 0) begin
                tmr_d[i] = tmr_q[i] == TW'(TIMEOUT_CYCLES) ? tmr_q[i] : tmr_q[i] + TW'(1);
                timeout  = timeout || tmr_q[i] == TW'(TIMEOUT_CYCLES - 1);
            end
        end
    end

    logic stab;
`ifdef AXI_WCHK_STABILITY_EN
    logic                    aw_v_q, aw_r_q, w_v_q, w_r_q, w_l_q, b_v_q, b_r_q;
    logic [LEN_WIDTH-1:0]    aw_len_q;
    logic [AW_TID_WIDTH-1:0] aw_tid_q, w_tid_q, b_tid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {aw_v_q, aw_r_q, w_v_q, w_r_q, w_l_q, b_v_q, b_r_q} <= '0;
            aw_len_q <= '0;
            aw_tid_q <= '0;
            w_tid_q  <= '0;
            b_tid_q  <= '0;
        end else begin
            {aw_v_q, aw_r_q, w_v_q, w_r_q, w_l_q, b_v_q, b_r_q} <=
                {aw_valid, aw_ready, w_valid, w_ready, w_last, b_valid, b_ready};
            aw_len_q <= aw_len;
            aw_tid_q <= aw_tid;
            w_tid_q  <= w_tid;
            b_tid_q  <= b_tid;
        end
    end

    assign stab = (aw_v_q && !aw_r_q && (!aw_valid || aw_len != aw_len_q || aw_tid != aw_tid_q)) ||
                  (w_v_q && !w_r_q && (!w_valid || w_last != w_l_q || w_tid != w_tid_q)) ||
                  (b_v_q && !b_r_q && (!b_valid || b_tid != b_tid_q));
`else
    assign stab = 1'b0;
`endif

    logic [7:0] viol, viol_q, err_q, new_bits;
    logic [2:0] low, first_q;
    logic       pulse_q, fev_q;
    logic [CNT_WIDTH-1:0] aw_cnt_q, w_cnt_q, b_cnt_q;

    assign viol = {stab, timeout, outst_ovf, b_no_outst,
                   wh && head_valid && ((!w_last && beat_q == {1'b0, head_len}) ||
                                        (AXI_MODE == 3 && w_tid != head_tid)),
                   wh && head_valid && w_last && beat_q < {1'b0, head_len},
                   wh && !head_valid,
                   awh && full && !pop};
    assign new_bits = viol_q & ~err_q;

    always_comb begin
        low = 3'd0;
        for (int i = 7; i >= 0; i--) low = new_bits[i] ? 3'(i) : low;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_len_q[wr_q] <= aw_len;
            q_tid_q[wr_q] <= aw_tid;
        end
    end

    // Violations are captured in viol_q first, so flags land one edge after the offending beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q     <= '0;
            rd_q     <= '0;
            count_q  <= '0;
            beat_q   <= '0;
            for (int i = 0; i < NUM_IDS; i++) outst_q[i] <= '0;
            for (int i = 0; i < 3; i++) tmr_q[i] <= '0;
            viol_q   <= '0;
            err_q    <= '0;
            pulse_q  <= 1'b0;
            first_q  <= '0;
            fev_q    <= 1'b0;
            aw_cnt_q <= '0;
            w_cnt_q  <= '0;
            b_cnt_q  <= '0;
        end else begin
            wr_q     <= push ? wr_q + PW'(1) : wr_q;
            rd_q     <= pop_mem ? rd_q + PW'(1) : rd_q;
            count_q  <= count_d;
            beat_q   <= beat_d;
            outst_q  <= outst_d;
            tmr_q    <= tmr_d;
            viol_q   <= check_en ? viol : '0;
            err_q    <= err_q | viol_q;
            pulse_q  <= |new_bits;
            first_q  <= !fev_q && |new_bits ? low : first_q;
            fev_q    <= fev_q || |new_bits;
            aw_cnt_q <= aw_cnt_q + CNT_WIDTH'(awh);
            w_cnt_q  <= w_cnt_q + CNT_WIDTH'(pop);
            b_cnt_q  <= b_cnt_q + CNT_WIDTH'(bh);
        end
    end

    assign err_vec         = err_q;
    assign err_pulse       = pulse_q;
    assign first_err       = first_q;
    assign first_err_valid = fev_q;
    assign aw_cnt          = aw_cnt_q;
    assign w_burst_cnt     = w_cnt_q;
    assign b_cnt           = b_cnt_q;
endmodule

// File: tb/tb_axi_w_protocol_checker.sv
// tb_axi_w_protocol_checker: directed and randomized bench for axi_w_protocol_checker against a queue-based model.
module tb_axi_w_protocol_checker;
    localparam int TO    = 16;
    localparam int DEPTH = 8;
    localparam int OW    = 3;
    localparam int OMAX  = 2 ** OW - 1;
`ifdef AXI_WCHK_STABILITY_EN
    localparam logic [7:0] STAB_EXP = 8'h80;
`else
    localparam logic [7:0] STAB_EXP = 8'h00;
`endif

    logic        clk = 1'b0, rst = 1'b0, check_en = 1'b1;
    logic        aw_valid = 1'b0, aw_ready = 1'b0;
    logic [0:0]  aw_tid = '0;
    logic [7:0]  aw_len = '0;
    logic        w_valid = 1'b0, w_ready = 1'b0, w_last = 1'b0;
    logic [0:0]  w_tid = '0;
    logic        b_valid = 1'b0, b_ready = 1'b0;
    logic [0:0]  b_tid = '0;
    logic [7:0]  err_vec;
    logic        err_pulse;
    logic [2:0]  first_err;
    logic        first_err_valid;
    logic [31:0] aw_cnt, w_burst_cnt, b_cnt;
    int          checks = 0, errors = 0;

    axi_w_protocol_checker #(
        .AXI_MODE(3), .AW_TID_WIDTH(1), .LEN_WIDTH(8), .AW_DEPTH(DEPTH),
        .OUTST_WIDTH(OW), .TIMEOUT_CYCLES(TO), .CNT_WIDTH(32)
    ) dut (
        .clk(clk), .rst(rst), .check_en(check_en),
        .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_tid(aw_tid), .aw_len(aw_len),
        .w_valid(w_valid), .w_ready(w_ready), .w_last(w_last), .w_tid(w_tid),
        .b_valid(b_valid), .b_ready(b_ready), .b_tid(b_tid),
        .err_vec(err_vec), .err_pulse(err_pulse), .first_err(first_err),
        .first_err_valid(first_err_valid), .aw_cnt(aw_cnt), .w_burst_cnt(w_burst_cnt), .b_cnt(b_cnt)
    );

    always #5 clk = ~clk;

    typedef struct { int len; int tid; } aw_t;
    aw_t         awq[$];
    int          beat, outst[2], run[3];
    int unsigned m_aw, m_w, m_b;
    logic [7:0]  m_vq, m_err;
    logic        m_pulse, m_fev;
    logic [2:0]  m_first;
`ifdef AXI_WCHK_STABILITY_EN
    logic        p_awv, p_awr, p_wv, p_wr, p_wl, p_bv, p_br;
    logic [7:0]  p_awl;
    logic [0:0]  p_awt, p_wt, p_bt;
`endif

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        awq.delete();
        beat = 0;
        outst = '{0, 0};
        run = '{0, 0, 0};
        {m_aw, m_w, m_b} = '0;
        {m_vq, m_err, m_pulse, m_fev, m_first} = '0;
`ifdef AXI_WCHK_STABILITY_EN
        {p_awv, p_awr, p_wv, p_wr, p_wl, p_bv, p_br, p_awl, p_awt, p_wt, p_bt} = '0;
`endif
    endtask

    task automatic model_step();
        logic       awh, wh, bh, done, has_head;
        logic [7:0] v, nb;
        logic [2:0] stall;
        aw_t        head, e;
        int         d;
        awh = aw_valid && aw_ready;
        wh  = w_valid && w_ready;
        bh  = b_valid && b_ready;
        v   = '0;
        nb  = m_vq & ~m_err;
        m_pulse = |nb;
        if (!m_fev && |nb) begin
            m_fev = 1'b1;
            for (int i = 7; i >= 0; i--) if (nb[i]) m_first = 3'(i);
        end
        m_err |= m_vq;
        has_head = awq.size() > 0 || awh;
        if (awq.size() > 0) head = awq[0];
        else begin
            head.len = int'(aw_len);
            head.tid = int'(aw_tid);
        end
        if (wh && !has_head) v[1] = 1'b1;
        if (wh && has_head && w_last && beat < head.len) v[2] = 1'b1;
        if (wh && has_head && !w_last && beat == head.len) v[3] = 1'b1;
        if (wh && has_head && int'(w_tid) != head.tid) v[3] = 1'b1;
        done = wh && w_last && has_head;
        if (awh) begin
            if (awq.size() == DEPTH && !done) v[0] = 1'b1;
            else begin
                e.len = int'(aw_len);
                e.tid = int'(aw_tid);
                awq.push_back(e);
            end
        end
        if (done) void'(awq.pop_front());
        if (wh) beat = w_last ? 0 : beat + 1;
        for (int id = 0; id < 2; id++) begin
            d = ((done && head.tid == id) ? 1 : 0) - ((bh && int'(b_tid) == id) ? 1 : 0);
            if (d > 0) begin
                if (outst[id] == OMAX) v[5] = 1'b1;
                else outst[id]++;
            end
            if (d < 0) begin
                if (outst[id] == 0) v[4] = 1'b1;
                else outst[id]--;
            end
        end
        stall = {b_valid && !b_ready, w_valid && !w_ready, aw_valid && !aw_ready};
        for (int c = 0; c < 3; c++) begin
            run[c] = stall[c] ? run[c] + 1 : 0;
            if (run[c] == TO) v[6] = 1'b1;
        end
`ifdef AXI_WCHK_STABILITY_EN
        if (p_awv && !p_awr && (!aw_valid || aw_len != p_awl || aw_tid != p_awt)) v[7] = 1'b1;
        if (p_wv && !p_wr && (!w_valid || w_last != p_wl || w_tid != p_wt)) v[7] = 1'b1;
        if (p_bv && !p_br && (!b_valid || b_tid != p_bt)) v[7] = 1'b1;
        {p_awv, p_awr, p_wv, p_wr, p_wl, p_bv, p_br} = {aw_valid, aw_ready, w_valid, w_ready, w_last, b_valid, b_ready};
        {p_awl, p_awt, p_wt, p_bt} = {aw_len, aw_tid, w_tid, b_tid};
`endif
        m_vq = check_en ? v : '0;
        m_aw += 32'(awh);
        m_w  += 32'(done);
        m_b  += 32'(bh);
    endtask

    task automatic cmp_all(input string ph);
        check({ph, ".err_vec"}, 64'(err_vec), 64'(m_err));
        check({ph, ".err_pulse"}, 64'(err_pulse), 64'(m_pulse));
        check({ph, ".first_err"}, 64'(first_err), 64'(m_first));
        check({ph, ".first_err_valid"}, 64'(first_err_valid), 64'(m_fev));
        check({ph, ".aw_cnt"}, 64'(aw_cnt), 64'(m_aw));
        check({ph, ".w_burst_cnt"}, 64'(w_burst_cnt), 64'(m_w));
        check({ph, ".b_cnt"}, 64'(b_cnt), 64'(m_b));
    endtask

    task automatic idle();
        {aw_valid, aw_ready, w_valid, w_ready, w_last, b_valid, b_ready} = '0;
    endtask

    task automatic tick(input string ph);
        @(posedge clk);
        model_step();
        #1;
        cmp_all(ph);
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        #1;
        model_reset();
        cmp_all("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic aw(input int len, input int tid);
        {aw_valid, aw_ready, aw_len, aw_tid} = {1'b1, 1'b1, 8'(len), 1'(tid)};
        tick("aw");
        aw_valid = 1'b0;
    endtask

    task automatic wbeat(input logic last, input int tid);
        {w_valid, w_ready, w_last, w_tid} = {1'b1, 1'b1, last, 1'(tid)};
        tick("w");
        w_valid = 1'b0;
    endtask

    task automatic bresp(input int tid);
        {b_valid, b_ready, b_tid} = {1'b1, 1'b1, 1'(tid)};
        tick("b");
        b_valid = 1'b0;
    endtask

    task automatic drive_random(input int perr, input bit toggle);
        bit hold;
        if (toggle && $urandom_range(0, 9) == 0) check_en = !check_en;
        hold = aw_valid && !aw_ready && $urandom_range(0, 99) >= perr;
        if (!hold) begin
            aw_valid = (awq.size() < DEPTH || perr > 0) && $urandom_range(0, 3) == 0;
            aw_len   = 8'($urandom_range(0, 3));
            aw_tid   = 1'($urandom_range(0, 1));
        end
        aw_ready = $urandom_range(0, 99) < 70;
        hold = w_valid && !w_ready && $urandom_range(0, 99) >= perr;
        if (!hold) begin
            w_valid = (awq.size() > 0 && $urandom_range(0, 1) == 1) || $urandom_range(0, 99) < perr;
            if (awq.size() > 0) begin
                w_last = beat >= awq[0].len;
                w_tid  = 1'(awq[0].tid);
            end else begin
                w_last = 1'($urandom_range(0, 1));
                w_tid  = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 99) < perr) w_last = !w_last;
            if ($urandom_range(0, 99) < perr) w_tid = ~w_tid;
        end
        w_ready = $urandom_range(0, 99) < 70;
        hold = b_valid && !b_ready && $urandom_range(0, 99) >= perr;
        if (!hold) begin
            b_tid = 1'($urandom_range(0, 1));
            if (outst[b_tid] == 0) b_tid = ~b_tid;
            b_valid = (outst[b_tid] > 0 && $urandom_range(0, 1) == 1) || $urandom_range(0, 99) < perr;
        end
        b_ready = $urandom_range(0, 99) < 70;
    endtask

    initial begin
        #2;
        do_reset();
        // clean burst
        aw(3, 0);
        for (int i = 0; i < 4; i++) wbeat(i == 3, 0);
        bresp(0);
        tick("t1");
        tick("t1");
        check("t1.err_vec", 64'(err_vec), 64'h00);
        check("t1.aw_cnt", 64'(aw_cnt), 64'd1);
        check("t1.w_burst_cnt", 64'(w_burst_cnt), 64'd1);
        check("t1.b_cnt", 64'(b_cnt), 64'd1);
        // early w_last
        do_reset();
        aw(3, 0);
        wbeat(1'b0, 0);
        wbeat(1'b1, 0);
        tick("t2");
        check("t2.err_vec", 64'(err_vec), 64'h04);
        check("t2.pulse_on", 64'(err_pulse), 64'd1);
        check("t2.first_err", 64'(first_err), 64'd2);
        check("t2.first_err_valid", 64'(first_err_valid), 64'd1);
        tick("t2");
        check("t2.pulse_off", 64'(err_pulse), 64'd0);
        // AW queue overflow, then push+pop at full
        do_reset();
        for (int i = 0; i < 9; i++) aw(0, 0);
        tick("t3");
        check("t3.ovf", 64'(err_vec), 64'h01);
        do_reset();
        for (int i = 0; i < 8; i++) aw(0, 0);
        {aw_valid, aw_ready, aw_len, aw_tid} = {1'b1, 1'b1, 8'd0, 1'b0};
        {w_valid, w_ready, w_last, w_tid} = {1'b1, 1'b1, 1'b1, 1'b0};
        tick("t3b");
        idle();
        tick("t3b");
        tick("t3b");
        check("t3b.err_vec", 64'(err_vec), 64'h00);
        check("t3b.aw_cnt", 64'(aw_cnt), 64'd9);
        check("t3b.w_burst_cnt", 64'(w_burst_cnt), 64'd1);
        // B with nothing outstanding, repeated
        do_reset();
        bresp(1);
        tick("t4");
        check("t4.err_vec", 64'(err_vec), 64'h10);
        check("t4.pulse", 64'(err_pulse), 64'd1);
        check("t4.first_err", 64'(first_err), 64'd4);
        {b_valid, b_ready, b_tid} = {1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 3; i++) begin
            tick("t4r");
            check("t4r.pulse", 64'(err_pulse), 64'd0);
            check("t4r.first_err", 64'(first_err), 64'd4);
        end
        // timeout boundary, then gated by check_en
        do_reset();
        {w_valid, w_ready} = 2'b10;
        for (int i = 0; i < TO - 1; i++) tick("t5a");
        idle();
        tick("t5a");
        tick("t5a");
        check("t5.short_stall", 64'(err_vec), 64'h00);
        {w_valid, w_ready} = 2'b10;
        for (int i = 0; i < TO; i++) tick("t5b");
        idle();
        tick("t5b");
        check("t5.timeout", 64'(err_vec), 64'h40);
        do_reset();
        check_en = 1'b0;
        {w_valid, w_ready} = 2'b10;
        for (int i = 0; i < TO + 4; i++) tick("t5c");
        idle();
        tick("t5c");
        tick("t5c");
        check("t5.gated", 64'(err_vec), 64'h00);
        check_en = 1'b1;
        // payload change while stalled
        do_reset();
        {aw_valid, aw_ready, aw_len, aw_tid} = {1'b1, 1'b0, 8'd2, 1'b0};
        tick("t6");
        aw_len = 8'd5;
        tick("t6");
        aw_ready = 1'b1;
        tick("t6");
        idle();
        tick("t6");
        tick("t6");
        check("t6.stability", 64'(err_vec & 8'h80), 64'(STAB_EXP));
        // reset mid-burst discards queue and beat state
        do_reset();
        aw(3, 1);
        wbeat(1'b0, 1);
        wbeat(1'b0, 1);
        #2;
        do_reset();
        aw(3, 0);
        for (int i = 0; i < 4; i++) wbeat(i == 3, 0);
        bresp(0);
        tick("t7");
        tick("t7");
        check("t7.err_vec", 64'(err_vec), 64'h00);
        check("t7.w_burst_cnt", 64'(w_burst_cnt), 64'd1);
        // randomized traffic with increasing error injection
        for (int s = 0; s < 6; s++) begin
            check_en = 1'b1;
            do_reset();
            for (int n = 0; n < 400; n++) begin
                drive_random(s * 2, s >= 4);
                tick("rand");
            end
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
